// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: fixed-latency pipelined RAM read, in-order output FIFO, credit-based req_ready.
// Optional IMEM_FLUSH_EN adds a flush input that discards all in-flight and buffered fetches.
module imem_fetch_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
`ifdef IMEM_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int WI = $clog2(DEPTH_WORDS);
  localparam int FD = LATENCY + 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(LATENCY + 2);
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  logic flush_i;
`ifdef IMEM_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  req_fault;
  logic [CW-1:0]         credit_reg;
  logic [CW-1:0]         fifo_cnt_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;

  logic [LATENCY-1:0]    stg_valid_reg;
  logic [LATENCY-1:0]    stg_err_reg;
  logic [ADDR_WIDTH-1:0] stg_addr_reg [LATENCY];

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  rd_en;
  logic [WI-1:0]         rd_idx;
  logic                  ld_in_range;
  logic                  ld_unused;

  logic [DATA_WIDTH-1:0] fifo_instr [FD];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FD];
  logic                  fifo_err   [FD];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready = ~flush_i & (credit_reg < CW'(LATENCY + 1));
  assign accept    = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;
  assign push      = stg_valid_reg[LATENCY-1] & ~flush_i;
  assign req_fault = (req_addr[1:0] != 2'b00) | (req_addr[ADDR_WIDTH-1:WI+2] != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid_reg <= '0;
      stg_err_reg   <= '0;
      for (int i = 0; i < LATENCY; i++) stg_addr_reg[i] <= '0;
    end else if (flush_i) begin
      stg_valid_reg <= '0;
    end else begin
      stg_valid_reg[0] <= accept;
      stg_err_reg[0]   <= req_fault;
      stg_addr_reg[0]  <= req_addr;
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid_reg[i] <= stg_valid_reg[i-1];
        stg_err_reg[i]   <= stg_err_reg[i-1];
        stg_addr_reg[i]  <= stg_addr_reg[i-1];
      end
    end
  end

  // RAM is read one stage before the FIFO write so its registered output lines up with the last stage.
  generate
    if (LATENCY == 1) begin : g_rd_at_accept
      assign rd_en  = accept & ~req_fault;
      assign rd_idx = req_addr[WI+1:2];
    end else begin : g_rd_in_pipe
      assign rd_en  = stg_valid_reg[LATENCY-2] & ~stg_err_reg[LATENCY-2];
      assign rd_idx = stg_addr_reg[LATENCY-2][WI+1:2];
    end
  endgenerate

  assign ld_in_range = (ld_addr[ADDR_WIDTH-1:WI+2] == '0);
  assign ld_unused   = ^ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (ld_we && ld_in_range) mem[ld_addr[WI+1:2]] <= ld_data;
    if (rd_en) ram_q <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_reg] <= stg_err_reg[LATENCY-1] ? NOP_INSTR : ram_q;
      fifo_addr[wr_ptr_reg]  <= stg_addr_reg[LATENCY-1];
      fifo_err[wr_ptr_reg]   <= stg_err_reg[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      credit_reg   <= '0;
    end else if (flush_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      credit_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
      case ({accept, pop})
        2'b10:   credit_reg <= credit_reg + CW'(1);
        2'b01:   credit_reg <= credit_reg - CW'(1);
        default: credit_reg <= credit_reg;
      endcase
    end
  end

  // Outputs are masked when empty so reset shows all-zero responses without clearing FIFO storage.
  assign rsp_valid = (fifo_cnt_reg != '0);
  assign rsp_instr = rsp_valid ? fifo_instr[rd_ptr_reg] : '0;
  assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr_reg]  : '0;
  assign rsp_err   = rsp_valid ? fifo_err[rd_ptr_reg]   : 1'b0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (default parameters, LATENCY=2, DEPTH_WORDS=256).
// Define IMEM_FLUSH_EN for both files to exercise the flush port.
module tb_imem_fetch_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
`ifdef IMEM_FLUSH_EN
  logic        flush;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] va [3];
  logic [31:0] vi [3];
  logic        ve [3];

  imem_fetch_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
`ifdef IMEM_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("check %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  // Issue va[0..2] back to back, then expect three consecutive in-order responses.
  task automatic stream3();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = va[i];
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stream_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stream_instr%0d", i), rsp_instr, vi[i]);
      chk($sformatf("stream_addr%0d", i), rsp_addr, va[i]);
      chk($sformatf("stream_err%0d", i), {31'd0, rsp_err}, {31'd0, ve[i]});
      tick();
    end
    chk("stream_drained", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int acc;
    logic seen;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
`ifdef IMEM_FLUSH_EN
    flush     = 1'b0;
`endif
    #8;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    chk("rst_rsp_addr", rsp_addr, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    #4 reset = 1'b0;
    tick();

    // Single fetch latency
    load(32'h0, 32'h0050_0093);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    chk("single_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("single_lat0", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("single_lat1", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("single_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_instr", rsp_instr, 32'h0050_0093);
    chk("single_addr", rsp_addr, 32'h0);
    chk("single_err", {31'd0, rsp_err}, 32'd0);
    tick();
    chk("single_consumed", {31'd0, rsp_valid}, 32'd0);

    // Streaming
    load(32'h0, 32'h11);
    load(32'h4, 32'h22);
    load(32'h8, 32'h33);
    va = '{32'h0, 32'h4, 32'h8};
    vi = '{32'h11, 32'h22, 32'h33};
    ve = '{1'b0, 1'b0, 1'b0};
    stream3();

    // Backpressure: credit limit of LATENCY+1 accepts
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      logic rdy;
      req_addr = 32'(4 * acc);
      rdy = req_ready;
      tick();
      if (rdy) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'd3);
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp_instr%0d", i), rsp_instr, 32'(8'h11 * (i + 1)));
      tick();
    end
    chk("bp_empty", {31'd0, rsp_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);

    // Faults: misaligned, out of range, then a good fetch
    va = '{32'h2, 32'h400, 32'h4};
    vi = '{32'h13, 32'h13, 32'h22};
    ve = '{1'b1, 1'b1, 1'b0};
    stream3();

    // Asynchronous reset with fetches outstanding
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(4 * i);
      tick();
    end
    req_valid = 1'b0;
    chk("pre_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_instr", rsp_instr, 32'd0);
    #2 reset = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("arst_no_stale", {31'd0, seen}, 32'd0);

`ifdef IMEM_FLUSH_EN
    // Flush with two fetches in flight
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(4 * i);
      tick();
    end
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_ready_low", {31'd0, req_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid0", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("flush_valid1", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("flush_valid2", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_valid = 1'b0;
    tick();
    chk("postflush_lat", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("postflush_valid", {31'd0, rsp_valid}, 32'd1);
    chk("postflush_instr", rsp_instr, 32'h33);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
